// File: rtl/reg_bank.sv
// 32 x DATA_W MIPS register bank: two combinational read ports and one synchronous write port.
// $zero is hardwired and $sp is preloaded on reset. Define REG_BANK_BYPASS_EN for write-through reads.
module reg_bank_cell #(
  parameter int              DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= RST_VAL;
    else if (we)   q <= d;
  end
endmodule

module reg_bank #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int SP_IDX   = 29,
  parameter int SP_RESET = 227
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              last_wr_valid,
  output logic [ADDR_W-1:0] last_wr_addr
);
  localparam int NREG = 1 << ADDR_W;

  logic                         wr_en;
  logic [NREG-1:0][DATA_W-1:0]  regs;

  assign wr_en   = RegWrite && (WriteReg != '0);
  assign regs[0] = '0;

  // Index 0 has no storage; every other index gets its own cell.
  generate
    for (genvar i = 1; i < NREG; i++) begin : g_cell
      reg_bank_cell #(
        .DATA_W  (DATA_W),
        .RST_VAL ((i == SP_IDX) ? DATA_W'(SP_RESET) : '0)
      ) u_cell (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_en && (WriteReg == ADDR_W'(i))),
        .d       (WriteData),
        .q       (regs[i])
      );
    end
  endgenerate

  always_comb begin
    ReadData1 = regs[ReadReg1];
    ReadData2 = regs[ReadReg2];
`ifdef REG_BANK_BYPASS_EN
    // wr_en already excludes index 0, so $zero never forwards.
    if (wr_en && (ReadReg1 == WriteReg)) ReadData1 = WriteData;
    if (wr_en && (ReadReg2 == WriteReg)) ReadData2 = WriteData;
`endif
    if (ReadReg1 == '0) ReadData1 = '0;
    if (ReadReg2 == '0) ReadData2 = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_wr_valid <= 1'b0;
      last_wr_addr  <= '0;
    end else begin
      last_wr_valid <= wr_en;
      if (wr_en) last_wr_addr <= WriteReg;
    end
  end
endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: vector table, reset corner sequences and a model-checked random burst.
// last_wr_* expectations go through a scoreboard queue popped after each edge.
module tb_reg_bank;
  logic        clk, clk_en, reset_n;
  logic        RegWrite;
  logic [4:0]  ReadReg1, ReadReg2, WriteReg;
  logic [31:0] WriteData, ReadData1, ReadData2;
  logic        last_wr_valid;
  logic [4:0]  last_wr_addr;

  int checks = 0;
  int errors = 0;

  typedef struct { logic v; logic [4:0] a; } lw_t;
  lw_t sb_q[$];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1, ra2;
    logic [31:0] st1, st2;   // stored contents before the edge
    logic        lwv;
    logic [4:0]  lwa;
  } vec_t;
  vec_t vecs[7];

  logic [31:0] mdl [32];
  logic [4:0]  mdl_lwa;

  reg_bank dut (
    .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .last_wr_valid(last_wr_valid), .last_wr_addr(last_wr_addr)
  );

  always #5 clk = clk_en ? ~clk : clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] stored, input logic [4:0] ra);
    logic [31:0] r;
    r = (ra == 5'd0) ? 32'd0 : stored;
`ifdef REG_BANK_BYPASS_EN
    if (RegWrite && WriteReg != 5'd0 && ra == WriteReg) r = WriteData;
`endif
    return r;
  endfunction

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    RegWrite = we; WriteReg = wa; WriteData = wd; ReadReg1 = ra1; ReadReg2 = ra2;
  endtask

  task automatic push(input logic v, input logic [4:0] a);
    lw_t e;
    e.v = v; e.a = a;
    sb_q.push_back(e);
  endtask

  // One clock edge, then compare the oldest scoreboard entry.
  task automatic cycle(input string name);
    lw_t e;
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      chk({name, ".lwv"}, {31'd0, last_wr_valid}, {31'd0, e.v});
      chk({name, ".lwa"}, {27'd0, last_wr_addr}, {27'd0, e.a});
    end
  endtask

  initial begin
    //        we    wa     wd             ra1    ra2    st1            st2            lwv   lwa
    vecs[0] = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd29, 32'h0,         32'd227,       1'b1, 5'd8};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd8,  32'h0,         32'hDEADBEEF,  1'b0, 5'd8};
    vecs[2] = '{1'b1, 5'd31, 32'h00000040, 5'd8,  5'd31, 32'hDEADBEEF,  32'h0,         1'b1, 5'd31};
    vecs[3] = '{1'b0, 5'd3,  32'h00000007, 5'd31, 5'd3,  32'h00000040,  32'h0,         1'b0, 5'd31};
    vecs[4] = '{1'b1, 5'd29, 32'd100,      5'd3,  5'd29, 32'h0,         32'd227,       1'b1, 5'd29};
    vecs[5] = '{1'b1, 5'd1,  32'h80000001, 5'd29, 5'd29, 32'd100,       32'd100,       1'b1, 5'd1};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd31, 32'h80000001,  32'h00000040,  1'b0, 5'd1};

    clk = 0; clk_en = 0; reset_n = 1;
    drive(0, 0, 0, 0, 0);

    // Async reset with no clock running.
    #3 reset_n = 0;
    #1 ReadReg1 = 5'd29; ReadReg2 = 5'd5;
    #1;
    chk("rst.r29", ReadData1, 32'd227);
    chk("rst.r5",  ReadData2, 32'd0);
    chk("rst.lwv", {31'd0, last_wr_valid}, 32'd0);
    chk("rst.lwa", {27'd0, last_wr_addr}, 32'd0);
    #2 reset_n = 1; clk_en = 1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
      #1;
      chk($sformatf("vec%0d.rd1", i), ReadData1, exp_rd(vecs[i].st1, vecs[i].ra1));
      chk($sformatf("vec%0d.rd2", i), ReadData2, exp_rd(vecs[i].st2, vecs[i].ra2));
      push(vecs[i].lwv, vecs[i].lwa);
      cycle($sformatf("vec%0d", i));
    end

    // Same-index read after the write edge shows the new value.
    drive(0, 0, 0, 5'd31, 5'd0);
    #1 chk("rw.after", ReadData1, 32'h40);
    chk("zero.after", ReadData2, 32'd0);

    // Reset asserted together with a write of r29=5: write lost.
    drive(1, 5'd29, 32'd5, 5'd29, 5'd8);
    reset_n = 0;
    #1 chk("midrst.r29", ReadData1, exp_rd(32'd227, 5'd29));
    chk("midrst.r8", ReadData2, 32'd0);
    @(posedge clk); #1;
    chk("midrst.edge.r29", ReadData1, exp_rd(32'd227, 5'd29));
    chk("midrst.edge.lwv", {31'd0, last_wr_valid}, 32'd0);
    chk("midrst.edge.lwa", {27'd0, last_wr_addr}, 32'd0);
    reset_n = 1;
    #1 chk("postrst.r29", ReadData1, exp_rd(32'd227, 5'd29));
    push(1'b1, 5'd29);
    cycle("postrst");
    drive(0, 0, 0, 5'd29, 5'd1);
    #1 chk("postrst.r29new", ReadData1, 32'd5);
    chk("postrst.r1", ReadData2, 32'd0);
    push(1'b0, 5'd29);
    cycle("idle");

    // Random burst against a behavioural model.
    foreach (mdl[i]) mdl[i] = 32'd0;
    mdl[29] = 32'd5;
    mdl_lwa = 5'd29;
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [4:0]  wa, ra1, ra2;
      logic [31:0] wd;
      we  = 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(we, wa, wd, ra1, ra2);
      #1;
      chk($sformatf("rnd%0d.rd1", n), ReadData1, exp_rd(mdl[ra1], ra1));
      chk($sformatf("rnd%0d.rd2", n), ReadData2, exp_rd(mdl[ra2], ra2));
      if (we && wa != 5'd0) begin
        mdl[wa] = wd;
        mdl_lwa = wa;
      end
      push(we && wa != 5'd0, mdl_lwa);
      cycle($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
